regbank_special_ctx: RTL
========================

Name: regbank_special_ctx

Overview:
- Parametrised special-register bank for the Cortex-M0 core: holds xPSR (APSR flags, EPSR T bit, IPSR), PRIMASK and CONTROL.
- Adds an MSR write port decoded by SYSm.
- Adds a hardware context stack that saves and restores flags, T and IPSR on exception entry and return. Nested exceptions and tail-chaining are supported.
- Sits beside the general register bank; read by the MRS path, the ALU flag logic and the exception controller.

Parameters:
- IPSR_W, 6, width of the IPSR exception-number field (psr[IPSR_W-1:0]); legal range 1..8.
- STACK_DEPTH, 4, number of nested contexts held (≥1).
- T_RESET, 1, reset value of psr[24].
- CONTROL_MASK, 32'h0000_0003, writable CONTROL bits; all other bits read 0.
- DW, $clog2(STACK_DEPTH+1), width of depth_out.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- flag_we  in  4  per-flag write enables, {N,Z,C,V}.
- flag_in  in  4  flag values, {N,Z,C,V}.
- t_we  in  1  EPSR T write enable.
- t_in  in  1  T value.
- msr_en  in  1  MSR write strobe.
- msr_sysm  in  8  MSR target: 0 = APSR, 16 = PRIMASK, 20 = CONTROL; any other value is ignored.
- msr_data  in  32  MSR write data.
- exc_entry  in  1  exception entry request, one cycle.
- exc_num  in  IPSR_W  exception number for the entry.
- exc_return  in  1  exception return request, one cycle.
- err_clr  in  1  clears the sticky error flags.
- psr_out  out  32  {NZCV,3'b0,T,(23-IPSR_W+1) zeros,IPSR}.
- primask_out  out  32  {31'b0,PM}.
- control_out  out  32  CONTROL & CONTROL_MASK.
- depth_out  out  DW  number of stacked contexts.
- stk_full  out  1  depth_out==STACK_DEPTH.
- stk_empty  out  1  depth_out==0.
- ovf_err  out  1  sticky: entry rejected because the stack was full.
- unf_err  out  1  sticky: return rejected because the stack was empty.

Behaviour:
- Reset (rst==0 at edge):
  - NZCV=0, T=T_RESET, IPSR=0.
  - PM=0, CONTROL=0.
  - depth=0, ovf_err=0, unf_err=0.
  - Stack RAM contents are don't-care.
- Outputs are registers; all writes are visible the cycle after the edge. No combinational input-to-output paths.
- Context word = {NZCV,T,IPSR}, 5+IPSR_W bits. A push always captures the pre-edge register values.
- Operation decode each cycle: E = exc_entry, R = exc_return.
- Plain entry (E & !R & !full):
  - stack[depth] <= context; depth+1.
  - IPSR <= exc_num.
- Entry when full (E & !R & full):
  - No push; IPSR unchanged.
  - ovf_err <= 1.
- Plain return (R & !E & !empty):
  - depth-1; NZCV, T, IPSR <= stack[depth-1].
  - Same-cycle flag_we, t_we and MSR APSR writes are discarded (pop wins).
- Return when empty (R & !E & empty):
  - unf_err <= 1; no state change from R.
- Tail-chain (E & R & !empty):
  - depth unchanged, no stack access.
  - IPSR <= exc_num; NZCV and T keep normal write rules.
- E & R & empty:
  - unf_err <= 1.
  - E is processed as a plain entry; since the stack is empty it is never full.
- Flag write priority per bit, highest first: pop restore, flag_we/t_we, MSR APSR, hold.
- MSR APSR writes psr[31:28] from msr_data[31:28] only; T and IPSR are not MSR-writable.
- MSR PRIMASK: PM <= msr_data[0].
- MSR CONTROL:
  - CONTROL <= msr_data & CONTROL_MASK.
  - In handler mode (IPSR≠0 pre-edge), bit 1 (SPSEL) holds its old value; other masked bits still write.
  - If the same-cycle entry or return changes IPSR, the mode check uses the pre-edge IPSR.
- PRIMASK and CONTROL are never touched by stack operations.
- Sticky errors:
  - Cleared by err_clr.
  - If a set condition coincides with err_clr, set wins.
- stk_full and stk_empty are decoded from the registered depth.
- Reset mid-operation: reset overrides every same-cycle request; the stack is logically emptied.

Test Plan:
1. Reset, then entry exc_num=11 with NZCV=4'b1010, T=1 → next cycle psr_out=32'hA100_000B, depth_out=1. Then exc_return → psr_out=32'hA100_0000, depth_out=0, stk_empty=1.
2. Nest STACK_DEPTH=4 entries with exc_num 3,4,5,6, then a 5th entry exc_num=7 → ovf_err=1, IPSR stays 6, depth_out=4. Four returns restore IPSR 5,4,3,0 in order; a further return sets unf_err=1.
3. Depth 1, IPSR=3: assert exc_entry and exc_return together with exc_num=14 → IPSR=14, depth_out stays 1, no stack write.
4. Return in the same cycle as flag_we=4'b1111, flag_in=4'b0000, where the stacked NZCV=4'b0110 → psr_out[31:28]=4'b0110.
5. MSR CONTROL with msr_data=32'hFFFF_FFFF in thread mode → control_out=32'h3. Clear it, enter an exception, repeat the MSR → control_out=32'h1. MSR sysm=8 → no register changes.
6. Assert err_clr and a full-stack entry in the same cycle → ovf_err stays 1. Next cycle err_clr alone → ovf_err=0. Drive rst low during a pending entry → all outputs return to reset values (psr_out=32'h0100_0000).

Source files
------------

// File: rtl/regbank_special_ctx.sv
// regbank_special_ctx: xPSR/PRIMASK/CONTROL bank with MSR port and nested exception context stack
module regbank_special_ctx #(
    parameter int IPSR_W = 6,
    parameter int STACK_DEPTH = 4,
    parameter bit T_RESET = 1'b1,
    parameter logic [31:0] CONTROL_MASK = 32'h0000_0003,
    parameter int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        flag_we,
    input  logic [3:0]        flag_in,
    input  logic              t_we,
    input  logic              t_in,
    input  logic              msr_en,
    input  logic [7:0]        msr_sysm,
    input  logic [31:0]       msr_data,
    input  logic              exc_entry,
    input  logic [IPSR_W-1:0] exc_num,
    input  logic              exc_return,
    input  logic              err_clr,
    output logic [31:0]       psr_out,
    output logic [31:0]       primask_out,
    output logic [31:0]       control_out,
    output logic [DW-1:0]     depth_out,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              ovf_err,
    output logic              unf_err
);
    localparam int CW = 5 + IPSR_W;
    localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              t_q, t_d;
    logic [IPSR_W-1:0] ipsr_q, ipsr_d;
    logic              pm_q, pm_d;
    logic [31:0]       control_q, control_d;
    logic [DW-1:0]     depth_q, depth_d, depth_m1;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic [CW-1:0]     stack_q [STACK_DEPTH];
    logic [CW-1:0]     ctx, pop_ctx;
    logic              full, empty, push, pop, tail;
    logic              msr_apsr, msr_pm, msr_ctrl;
    logic [31:0]       ctrl_wr;
    always_comb begin
        full      = depth_q == DW'(STACK_DEPTH);
        empty     = depth_q == '0;
        push      = exc_entry && (exc_return ? empty : !full);
        pop       = exc_return && !exc_entry && !empty;
        tail      = exc_entry && exc_return && !empty;
        depth_m1  = depth_q - DW'(1);
        ctx       = {nzcv_q, t_q, ipsr_q};
        pop_ctx   = stack_q[depth_m1[AW-1:0]];
        msr_apsr  = msr_en && msr_sysm == 8'd0;
        msr_pm    = msr_en && msr_sysm == 8'd16;
        msr_ctrl  = msr_en && msr_sysm == 8'd20;
        ctrl_wr   = msr_data & CONTROL_MASK;
        nzcv_d    = pop ? pop_ctx[CW-1:CW-4]
                  : (flag_we & flag_in) | (~flag_we & (msr_apsr ? msr_data[31:28] : nzcv_q));
        t_d       = pop ? pop_ctx[IPSR_W] : t_we ? t_in : t_q;
        ipsr_d    = pop ? pop_ctx[IPSR_W-1:0] : (push || tail) ? exc_num : ipsr_q;
        pm_d      = msr_pm ? msr_data[0] : pm_q;
        // SPSEL is frozen while in handler mode, judged on the pre-edge IPSR
        control_d = !msr_ctrl ? control_q
                  : |ipsr_q ? {ctrl_wr[31:2], control_q[1], ctrl_wr[0]} : ctrl_wr;
        depth_d   = push ? depth_q + DW'(1) : pop ? depth_m1 : depth_q;
        ovf_d     = (exc_entry && !exc_return && full) || (ovf_q && !err_clr);
        unf_d     = (exc_return && empty) || (unf_q && !err_clr);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            nzcv_q    <= '0;
            t_q       <= T_RESET;
            ipsr_q    <= '0;
            pm_q      <= 1'b0;
            control_q <= '0;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            nzcv_q    <= nzcv_d;
            t_q       <= t_d;
            ipsr_q    <= ipsr_d;
            pm_q      <= pm_d;
            control_q <= control_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst && push) stack_q[depth_q[AW-1:0]] <= ctx;
    end
    assign psr_out     = {nzcv_q, 3'b000, t_q, {(24-IPSR_W){1'b0}}, ipsr_q};
    assign primask_out = {31'b0, pm_q};
    assign control_out = control_q;
    assign depth_out   = depth_q;
    assign stk_full    = full;
    assign stk_empty   = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
endmodule
